// File: rtl/call_scheduler_pkg.sv
// Shared types and defaults for the elevator call scheduler.
// Direction encodings double as the scheduler FSM state.
package call_scheduler_pkg;

    localparam int FLOORS_DEF  = 8;
    localparam int FLOOR_W_DEF = 3;

    typedef enum logic [1:0] {
        DIR_IDLE = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DOWN = 2'b10
    } dir_e;

endpackage

// File: rtl/call_scheduler_if.sv
// Button, car-status and scheduling bundle between the panels,
// the motion/door FSM and the call scheduler.
interface call_scheduler_if
    import call_scheduler_pkg::*;
#(
    parameter int FLOORS  = FLOORS_DEF,
    parameter int FLOOR_W = FLOOR_W_DEF
);

    logic               power;
    logic [FLOORS-1:0]  up_btn;
    logic [FLOORS-1:0]  down_btn;
    logic [FLOORS-1:0]  car_btn;
    logic [FLOOR_W-1:0] cur_floor;
    logic               moving;
    logic               door_evt;

    logic [FLOORS-1:0]  upcall;
    logic [FLOORS-1:0]  downcall;
    logic [FLOORS-1:0]  floor_req;
    logic [1:0]         dir;
    logic               target_valid;
    logic [FLOOR_W-1:0] target_floor;
    logic               stop_here;

    modport master (
        output power, up_btn, down_btn, car_btn,
        output cur_floor, moving, door_evt,
        input  upcall, downcall, floor_req, dir,
        input  target_valid, target_floor, stop_here
    );

    modport slave (
        input  power, up_btn, down_btn, car_btn,
        input  cur_floor, moving, door_evt,
        output upcall, downcall, floor_req, dir,
        output target_valid, target_floor, stop_here
    );

endinterface

// File: rtl/call_scheduler_floor_scan.sv
// Nearest set bit strictly above (up_i=1) or below (up_i=0) an index.
// Purely combinational; scan is bounded to 0..FLOORS-1.
module call_scheduler_floor_scan #(
    parameter int FLOORS  = 8,
    parameter int FLOOR_W = 3
) (
    input  logic [FLOORS-1:0]  vec_i,
    input  logic [FLOOR_W-1:0] idx_i,
    input  logic               up_i,
    output logic               valid_o,
    output logic [FLOOR_W-1:0] idx_o
);

    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        if (up_i) begin
            // descending loop: the last hit is the lowest floor above
            for (int i = FLOORS - 1; i >= 0; i--) begin
                if (vec_i[i] && i > int'(idx_i)) begin
                    valid_o = 1'b1;
                    idx_o   = FLOOR_W'(i);
                end
            end
        end else begin
            for (int i = 0; i < FLOORS; i++) begin
                if (vec_i[i] && i < int'(idx_i)) begin
                    valid_o = 1'b1;
                    idx_o   = FLOOR_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/call_scheduler.sv
// SCAN-policy call scheduler: latches hall/car requests, clears them
// on door events and picks travel direction and next target floor.
module call_scheduler
    import call_scheduler_pkg::*;
#(
    parameter int FLOORS  = FLOORS_DEF,
    parameter int FLOOR_W = FLOOR_W_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    call_scheduler_if.slave bus
);

    logic [FLOORS-1:0]  upcall_q, upcall_d;
    logic [FLOORS-1:0]  downcall_q, downcall_d;
    logic [FLOORS-1:0]  floor_req_q, floor_req_d;
    dir_e               dir_q, dir_d;
    logic               tgt_valid_q, tgt_valid_d;
    logic [FLOOR_W-1:0] tgt_floor_q, tgt_floor_d;
    logic               stop_q, stop_d;

    logic [FLOOR_W-1:0] cur;
    logic [FLOORS-1:0]  all_req, above_m, below_m;
    logic [FLOORS-1:0]  up_btn_m, dn_btn_m;
    logic [FLOORS-1:0]  clr_up, clr_dn, clr_fr;
    logic               any_above, any_below, any_here;
    logic               scan_up_v, scan_dn_v;
    logic [FLOOR_W-1:0] scan_up_idx, scan_dn_idx;
    logic               fb_up_v, fb_dn_v, low_v;
    logic [FLOOR_W-1:0] fb_up_idx, fb_dn_idx, low_idx;

    always_comb begin
        cur = bus.cur_floor;
        if (int'(bus.cur_floor) >= FLOORS) cur = FLOOR_W'(FLOORS - 1);
    end

    always_comb begin
        all_req = upcall_q | downcall_q | floor_req_q;
        for (int i = 0; i < FLOORS; i++) begin
            above_m[i] = (i > int'(cur));
            below_m[i] = (i < int'(cur));
        end
        any_above = |(all_req & above_m);
        any_below = |(all_req & below_m);
        any_here  = all_req[cur];
    end

    call_scheduler_floor_scan #(
        .FLOORS  (FLOORS),
        .FLOOR_W (FLOOR_W)
    ) u_scan_up (
        .vec_i   (floor_req_q | upcall_q),
        .idx_i   (cur),
        .up_i    (1'b1),
        .valid_o (scan_up_v),
        .idx_o   (scan_up_idx)
    );

    call_scheduler_floor_scan #(
        .FLOORS  (FLOORS),
        .FLOOR_W (FLOOR_W)
    ) u_scan_dn (
        .vec_i   (floor_req_q | downcall_q),
        .idx_i   (cur),
        .up_i    (1'b0),
        .valid_o (scan_dn_v),
        .idx_o   (scan_dn_idx)
    );

    // Fallbacks: farthest opposite-direction call, and lowest pending
    always_comb begin
        fb_up_v   = 1'b0;
        fb_up_idx = '0;
        fb_dn_v   = 1'b0;
        fb_dn_idx = '0;
        low_v     = 1'b0;
        low_idx   = '0;
        for (int i = 0; i < FLOORS; i++) begin
            if (downcall_q[i] && above_m[i]) begin
                fb_up_v   = 1'b1;
                fb_up_idx = FLOOR_W'(i);
            end
        end
        for (int i = FLOORS - 1; i >= 0; i--) begin
            if (upcall_q[i] && below_m[i]) begin
                fb_dn_v   = 1'b1;
                fb_dn_idx = FLOOR_W'(i);
            end
            if (all_req[i]) begin
                low_v   = 1'b1;
                low_idx = FLOOR_W'(i);
            end
        end
    end

    always_comb begin
        up_btn_m           = bus.up_btn;
        up_btn_m[FLOORS-1] = 1'b0;
        dn_btn_m           = bus.down_btn;
        dn_btn_m[0]        = 1'b0;
        clr_up             = '0;
        clr_dn             = '0;
        clr_fr             = '0;
        if (bus.door_evt) begin
            clr_fr[cur] = 1'b1;
            unique case (dir_q)
                DIR_UP: begin
                    clr_up[cur] = 1'b1;
                    clr_dn[cur] = !any_above;
                end
                DIR_DOWN: begin
                    clr_dn[cur] = 1'b1;
                    clr_up[cur] = !any_below;
                end
                default: begin
                    clr_up[cur] = 1'b1;
                    clr_dn[cur] = 1'b1;
                end
            endcase
        end
        upcall_d    = (upcall_q | up_btn_m) & ~clr_up;
        downcall_d  = (downcall_q | dn_btn_m) & ~clr_dn;
        floor_req_d = (floor_req_q | bus.car_btn) & ~clr_fr;
    end

    always_comb begin
        dir_d = dir_q;
        if (!bus.moving) begin
            unique case (dir_q)
                DIR_IDLE: begin
                    if (any_here)       dir_d = DIR_IDLE;
                    else if (any_above) dir_d = DIR_UP;
                    else if (any_below) dir_d = DIR_DOWN;
                end
                DIR_UP: begin
                    if (any_above)      dir_d = DIR_UP;
                    else if (any_below) dir_d = DIR_DOWN;
                    else                dir_d = DIR_IDLE;
                end
                DIR_DOWN: begin
                    if (any_below)      dir_d = DIR_DOWN;
                    else if (any_above) dir_d = DIR_UP;
                    else                dir_d = DIR_IDLE;
                end
                default: dir_d = DIR_IDLE;
            endcase
        end
    end

    always_comb begin
        tgt_valid_d = 1'b0;
        tgt_floor_d = '0;
        stop_d      = floor_req_q[cur];
        unique case (dir_d)
            DIR_UP: begin
                if (scan_up_v) begin
                    tgt_valid_d = 1'b1;
                    tgt_floor_d = scan_up_idx;
                end else if (fb_up_v) begin
                    tgt_valid_d = 1'b1;
                    tgt_floor_d = fb_up_idx;
                end
                stop_d = stop_d | upcall_q[cur] |
                         (!any_above && downcall_q[cur]);
            end
            DIR_DOWN: begin
                if (scan_dn_v) begin
                    tgt_valid_d = 1'b1;
                    tgt_floor_d = scan_dn_idx;
                end else if (fb_dn_v) begin
                    tgt_valid_d = 1'b1;
                    tgt_floor_d = fb_dn_idx;
                end
                stop_d = stop_d | downcall_q[cur] |
                         (!any_below && upcall_q[cur]);
            end
            default: begin
                tgt_valid_d = low_v;
                tgt_floor_d = low_idx;
                stop_d = stop_d | upcall_q[cur] | downcall_q[cur];
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !bus.power) begin
            upcall_q    <= '0;
            downcall_q  <= '0;
            floor_req_q <= '0;
            dir_q       <= DIR_IDLE;
            tgt_valid_q <= 1'b0;
            tgt_floor_q <= '0;
            stop_q      <= 1'b0;
        end else begin
            upcall_q    <= upcall_d;
            downcall_q  <= downcall_d;
            floor_req_q <= floor_req_d;
            dir_q       <= dir_d;
            tgt_valid_q <= tgt_valid_d;
            tgt_floor_q <= tgt_floor_d;
            stop_q      <= stop_d;
        end
    end

    assign bus.upcall       = upcall_q;
    assign bus.downcall     = downcall_q;
    assign bus.floor_req    = floor_req_q;
    assign bus.dir          = dir_q;
    assign bus.target_valid = tgt_valid_q;
    assign bus.target_floor = tgt_floor_q;
    assign bus.stop_here    = stop_q;

endmodule

// File: tb/tb_call_scheduler.sv
// Directed and randomized bench for call_scheduler against a
// floor-by-floor reference model of the SCAN rules.
module tb_call_scheduler;

    localparam int F = 8;
    localparam int W = 3;

    logic clk = 1'b0;
    logic rst_n;

    call_scheduler_if #(.FLOORS(F), .FLOOR_W(W)) bus ();

    call_scheduler #(.FLOORS(F), .FLOOR_W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [F-1:0] m_up, m_dn, m_fr;
    int           m_dir, m_tf;
    bit           m_tv, m_sh;

    function automatic bit pend(int f);
        return m_up[f] | m_dn[f] | m_fr[f];
    endfunction

    // Next-state from the rules, evaluated on inputs seen at the edge
    task automatic model_step();
        logic [F-1:0] nu, nd, nf;
        int c, ndir;
        bit ab, be, he;
        if (!rst_n || !bus.power) begin
            m_up = '0; m_dn = '0; m_fr = '0;
            m_dir = 0; m_tv = 0; m_tf = 0; m_sh = 0;
            return;
        end
        c = (int'(bus.cur_floor) >= F) ? F - 1 : int'(bus.cur_floor);
        ab = 0; be = 0;
        for (int f = 0; f < F; f++) begin
            if (pend(f) && f > c) ab = 1;
            if (pend(f) && f < c) be = 1;
        end
        he = pend(c);
        for (int f = 0; f < F; f++) begin
            nu[f] = m_up[f] | (bus.up_btn[f] && f != F - 1);
            nd[f] = m_dn[f] | (bus.down_btn[f] && f != 0);
            nf[f] = m_fr[f] | bus.car_btn[f];
        end
        if (bus.door_evt) begin
            nf[c] = 0;
            if (m_dir == 1) begin
                nu[c] = 0;
                if (!ab) nd[c] = 0;
            end else if (m_dir == 2) begin
                nd[c] = 0;
                if (!be) nu[c] = 0;
            end else begin
                nu[c] = 0;
                nd[c] = 0;
            end
        end
        ndir = m_dir;
        if (!bus.moving) begin
            if (m_dir == 0)      ndir = he ? 0 : ab ? 1 : be ? 2 : 0;
            else if (m_dir == 1) ndir = ab ? 1 : be ? 2 : 0;
            else                 ndir = be ? 2 : ab ? 1 : 0;
        end
        m_tv = 0; m_tf = 0;
        if (ndir == 1) begin
            for (int f = c + 1; f < F; f++)
                if (!m_tv && (m_fr[f] || m_up[f])) begin m_tv = 1; m_tf = f; end
            for (int f = F - 1; f > c; f--)
                if (!m_tv && m_dn[f]) begin m_tv = 1; m_tf = f; end
        end else if (ndir == 2) begin
            for (int f = c - 1; f >= 0; f--)
                if (!m_tv && (m_fr[f] || m_dn[f])) begin m_tv = 1; m_tf = f; end
            for (int f = 0; f < c; f++)
                if (!m_tv && m_up[f]) begin m_tv = 1; m_tf = f; end
        end else begin
            for (int f = 0; f < F; f++)
                if (!m_tv && pend(f)) begin m_tv = 1; m_tf = f; end
        end
        m_sh = m_fr[c]
            || (ndir == 1 && (m_up[c] || (!ab && m_dn[c])))
            || (ndir == 2 && (m_dn[c] || (!be && m_up[c])))
            || (ndir == 0 && (m_up[c] || m_dn[c]));
        m_up = nu; m_dn = nd; m_fr = nf; m_dir = ndir;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        chk("upcall", bus.upcall, m_up);
        chk("downcall", bus.downcall, m_dn);
        chk("floor_req", bus.floor_req, m_fr);
        chk("dir", bus.dir, m_dir);
        chk("target_valid", bus.target_valid, m_tv);
        chk("target_floor", bus.target_floor, m_tf);
        chk("stop_here", bus.stop_here, m_sh);
    endtask

    task automatic no_btn();
        bus.up_btn = '0; bus.down_btn = '0; bus.car_btn = '0;
    endtask

    int cf;

    initial begin
        rst_n = 0; bus.power = 1; no_btn();
        bus.cur_floor = 0; bus.moving = 0; bus.door_evt = 0;
        m_up = '0; m_dn = '0; m_fr = '0;
        m_dir = 0; m_tv = 0; m_tf = 0; m_sh = 0;
        step(); step();
        chk("rst0_dir", bus.dir, 2'b00);
        rst_n = 1;
        // reset and power flush
        bus.up_btn = 8'h12; bus.car_btn = 8'h40; step(); no_btn(); step();
        chk("pre_rst_up", bus.upcall, 8'h12);
        rst_n = 0; step();
        chk("rst_up", bus.upcall, 8'h00);
        chk("rst_fr", bus.floor_req, 8'h00);
        chk("rst_tv", bus.target_valid, 1'b0);
        rst_n = 1;
        bus.up_btn = 8'h12; step(); no_btn(); step();
        bus.power = 0; bus.car_btn = 8'h04; step(); no_btn();
        chk("pwr_up", bus.upcall, 8'h00);
        chk("pwr_fr", bus.floor_req, 8'h00);
        chk("pwr_dir", bus.dir, 2'b00);
        bus.power = 1; step();
        // single car request
        bus.car_btn = 8'h20; step(); no_btn();
        chk("single_fr", bus.floor_req, 8'h20);
        step();
        chk("single_dir", bus.dir, 2'b01);
        chk("single_tf", bus.target_floor, 3'd5);
        bus.cur_floor = 5; step();
        bus.door_evt = 1; step(); bus.door_evt = 0; step();
        chk("single_clr_fr", bus.floor_req, 8'h00);
        chk("single_clr_dir", bus.dir, 2'b00);
        // SCAN ordering
        bus.cur_floor = 2;
        bus.up_btn = 8'h10; bus.down_btn = 8'h08; bus.car_btn = 8'h40;
        step(); no_btn(); step();
        chk("scan_dir", bus.dir, 2'b01);
        chk("scan_tf4", bus.target_floor, 3'd4);
        bus.cur_floor = 4; step();
        bus.door_evt = 1; step(); bus.door_evt = 0; step();
        chk("scan_up_clr", bus.upcall, 8'h00);
        chk("scan_tf6", bus.target_floor, 3'd6);
        bus.cur_floor = 6; step();
        bus.door_evt = 1; step(); bus.door_evt = 0; step();
        chk("scan_dir_dn", bus.dir, 2'b10);
        chk("scan_tf3", bus.target_floor, 3'd3);
        bus.cur_floor = 3; step();
        bus.door_evt = 1; step(); bus.door_evt = 0; step();
        // turnaround clear at the top
        bus.cur_floor = 0; bus.down_btn = 8'h80; step(); no_btn(); step();
        chk("turn_dir", bus.dir, 2'b01);
        chk("turn_tf", bus.target_floor, 3'd7);
        bus.moving = 1; bus.cur_floor = 7; step();
        bus.door_evt = 1; step();
        bus.door_evt = 0; bus.moving = 0; step();
        chk("turn_dn", bus.downcall, 8'h00);
        chk("turn_idle", bus.dir, 2'b00);
        // masking and same-cycle press/clear
        bus.up_btn = 8'h80; bus.down_btn = 8'h01; step(); no_btn();
        chk("mask_up", bus.upcall, 8'h00);
        chk("mask_dn", bus.downcall, 8'h00);
        bus.cur_floor = 3; bus.car_btn = 8'h08; bus.door_evt = 1; step();
        no_btn(); bus.door_evt = 0;
        chk("simul_fr", bus.floor_req, 8'h00);
        // direction freeze while moving
        bus.cur_floor = 2; bus.car_btn = 8'h40; step(); no_btn(); step();
        chk("frz_up0", bus.dir, 2'b01);
        bus.moving = 1; bus.cur_floor = 7; step(); step();
        chk("frz_up1", bus.dir, 2'b01);
        bus.moving = 0; step();
        chk("frz_dn", bus.dir, 2'b10);
        bus.cur_floor = 6; step();
        bus.door_evt = 1; step(); bus.door_evt = 0; step();
        // randomized traffic
        cf = 6;
        for (int n = 0; n < 800; n++) begin
            bus.up_btn   = 8'($urandom & $urandom & $urandom);
            bus.down_btn = 8'($urandom & $urandom & $urandom);
            bus.car_btn  = 8'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 1) == 0 && cf < F - 1) cf++;
                else if (cf > 0) cf--;
            end
            bus.cur_floor = W'(cf);
            bus.moving    = ($urandom_range(0, 3) == 0);
            bus.door_evt  = ($urandom_range(0, 4) == 0);
            bus.power     = ($urandom_range(0, 59) != 0);
            rst_n         = ($urandom_range(0, 99) != 0);
            step();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
